wb_sram16_ctrl: RTL and testbench

- Wishbone slave that sits directly downstream of the 3-port bus arbiter, on its shared slave port.
- Converts 32-bit Wishbone single accesses into one or two 16-bit asynchronous SRAM half-word accesses.
- Uses byte-lane strobes and has a configurable number of wait cycles per phase.
- All SRAM-side outputs are registered.

---
 rtl/wb_sram16_ctrl_if.sv | 24 ++
 rtl/wb_sram16_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_wb_sram16_ctrl.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sram16_ctrl_if.sv
// Wishbone single-access bus between the shared arbiter port and the SRAM controller.
// Slave side: adr/dat/we/sel/stb/cyc in; dat_o/ack_o out.
interface wb_sram16_ctrl_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i,
    output wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i,
    input  wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_sram16_ctrl.sv
// 32-bit Wishbone slave to 16-bit async SRAM, one or two half-word phases.
// Ports: clk, rst_n, wb (slave modport), sram_* pad signals (all registered).
module wb_sram16_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_sram16_ctrl_if.slave   wb,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(WAIT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LO      = 3'd1;
  localparam logic [2:0] S_LO_HOLD = 3'd2;
  localparam logic [2:0] S_HI      = 3'd3;
  localparam logic [2:0] S_HI_HOLD = 3'd4;
  localparam logic [2:0] S_ACK     = 3'd5;
  localparam logic [2:0] S_RECOVER = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-2:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dqo_q, dqo_d;
  logic              dqoe_q, dqoe_d;
  logic              ce_q, ce_d;
  logic              oe_q, oe_d;
  logic              wen_q, wen_d;
  logic              lb_q, lb_d;
  logic              ub_q, ub_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdat_q;
  logic [15:0]       rd_lo_q;
  logic              smp_lo_q, smp_lo_d;
  logic              smp_hi_q, smp_hi_d;

  logic busy, abort, cnt_done, hi_en, hi_ph;
  logic unused_adr;

  assign unused_adr = ^{wb.wb_adr_i[31:ADDR_W+1],
                        wb.wb_adr_i[1:0]};

  assign busy = (state_q == S_LO) | (state_q == S_LO_HOLD)
              | (state_q == S_HI) | (state_q == S_HI_HOLD);
  assign abort    = busy & ~wb.wb_cyc_i;
  assign cnt_done = (cnt_q == '0);
  assign hi_en    = ~we_q | (|sel_q[3:2]);
  assign hi_ph    = (state_q == S_HI);

  // Sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (wb.wb_cyc_i && wb.wb_stb_i) begin
            adr_d = wb.wb_adr_i[ADDR_W:2];
            dat_d = wb.wb_dat_i;
            we_d  = wb.wb_we_i;
            sel_d = wb.wb_sel_i;
            cnt_d = RELOAD;
            if (!wb.wb_we_i || (|wb.wb_sel_i[1:0]))
              state_d = S_LO;
            else if (|wb.wb_sel_i[3:2])
              state_d = S_HI;
            else
              state_d = S_ACK;
          end
        end
        S_LO: begin
          if (!cnt_done) begin
            cnt_d = cnt_q - 1'b1;
          end else if (we_q) begin
            state_d = S_LO_HOLD;
          end else begin
            state_d = S_HI;
            cnt_d   = RELOAD;
          end
        end
        S_LO_HOLD: begin
          if (hi_en) begin
            state_d = S_HI;
            cnt_d   = RELOAD;
          end else begin
            state_d = S_ACK;
          end
        end
        S_HI: begin
          if (!cnt_done)
            cnt_d = cnt_q - 1'b1;
          else if (we_q)
            state_d = S_HI_HOLD;
          else
            state_d = S_ACK;
        end
        S_HI_HOLD: state_d = S_ACK;
        S_ACK:     state_d = S_RECOVER;
        S_RECOVER: begin
          // stb lingers one cycle past ack behind the arbiter
          if (!wb.wb_stb_i)
            state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pad outputs lag the state by one registered cycle
  always_comb begin
    addr_d = addr_q;
    dqo_d  = dqo_q;
    dqoe_d = 1'b0;
    ce_d   = 1'b1;
    oe_d   = 1'b1;
    wen_d  = 1'b1;
    lb_d   = 1'b1;
    ub_d   = 1'b1;
    if (!abort) begin
      unique case (state_q)
        S_LO, S_HI: begin
          ce_d   = 1'b0;
          addr_d = {adr_q, hi_ph};
          if (we_q) begin
            wen_d  = 1'b0;
            dqoe_d = 1'b1;
            dqo_d  = hi_ph ? dat_q[31:16] : dat_q[15:0];
            lb_d   = ~(hi_ph ? sel_q[2] : sel_q[0]);
            ub_d   = ~(hi_ph ? sel_q[3] : sel_q[1]);
          end else begin
            oe_d = 1'b0;
            lb_d = 1'b0;
            ub_d = 1'b0;
          end
        end
        S_LO_HOLD, S_HI_HOLD: begin
          ce_d   = 1'b0;
          dqoe_d = dqoe_q;
          lb_d   = lb_q;
          ub_d   = ub_q;
        end
        default: ;
      endcase
    end
  end

  // Read data is sampled at the end of the last strobe cycle
  assign smp_lo_d = (state_q == S_LO) & ~we_q
                  & cnt_done & ~abort;
  assign smp_hi_d = (state_q == S_HI) & ~we_q
                  & cnt_done & ~abort;
  assign ack_d    = (state_q == S_ACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      dqo_q    <= '0;
      dqoe_q   <= 1'b0;
      ce_q     <= 1'b1;
      oe_q     <= 1'b1;
      wen_q    <= 1'b1;
      lb_q     <= 1'b1;
      ub_q     <= 1'b1;
      ack_q    <= 1'b0;
      rdat_q   <= '0;
      rd_lo_q  <= '0;
      smp_lo_q <= 1'b0;
      smp_hi_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      dqo_q    <= dqo_d;
      dqoe_q   <= dqoe_d;
      ce_q     <= ce_d;
      oe_q     <= oe_d;
      wen_q    <= wen_d;
      lb_q     <= lb_d;
      ub_q     <= ub_d;
      ack_q    <= ack_d;
      smp_lo_q <= smp_lo_d;
      smp_hi_q <= smp_hi_d;
      if (smp_lo_q)
        rd_lo_q <= sram_dq_i;
      // Word updates together with ack, so an aborted read leaves it intact
      if (smp_hi_q)
        rdat_q <= {sram_dq_i, rd_lo_q};
    end
  end

  assign sram_addr   = addr_q;
  assign sram_dq_o   = dqo_q;
  assign sram_dq_oe  = dqoe_q;
  assign sram_ce_n   = ce_q;
  assign sram_oe_n   = oe_q;
  assign sram_we_n   = wen_q;
  assign sram_lb_n   = lb_q;
  assign sram_ub_n   = ub_q;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = rdat_q;

endmodule

// File: tb/tb_wb_sram16_ctrl.sv
// Bench for wb_sram16_ctrl: async SRAM model, byte-lane reference memory.
// Latency and data are predicted from the bus-level access rules.
module tb_wb_sram16_ctrl;
  localparam int W  = 2;
  localparam int AW = 18;
  localparam logic [72:0] RST_VEC =
    {5'b11111, 1'b0, 18'h0, 16'h0, 1'b0, 32'h0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_sram16_ctrl_if bus();
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n;
  logic          sram_we_n, sram_lb_n, sram_ub_n;

  wb_sram16_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .wb(bus),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n),
    .sram_ub_n(sram_ub_n)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:4095];
  logic [15:0] ref_mem [int];

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n && !sram_dq_oe)
                   ? mem[sram_addr[11:0]] : 16'h0000;

  always @(posedge sram_we_n) begin
    if (rst_n && !sram_ce_n && sram_dq_oe) begin
      if (!sram_lb_n) mem[sram_addr[11:0]][7:0]  = sram_dq_o[7:0];
      if (!sram_ub_n) mem[sram_addr[11:0]][15:8] = sram_dq_o[15:8];
    end
  end

  int we_low = 0, ce_low = 0, we_fall = 0;
  logic lb_seen = 1'b1, ub_seen = 1'b1;
  logic [AW-1:0] rd_log [$];

  always @(posedge clk) begin
    if (!sram_we_n) begin
      we_low++;
      lb_seen = sram_lb_n;
      ub_seen = sram_ub_n;
    end
    if (!sram_ce_n) ce_low++;
    if (!sram_ce_n && !sram_oe_n) rd_log.push_back(sram_addr);
  end
  always @(negedge sram_we_n) we_fall++;

  function automatic logic [72:0] pins();
    return {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n,
            sram_dq_oe, sram_addr, sram_dq_o,
            bus.wb_ack_o, bus.wb_dat_o};
  endfunction

  function automatic logic [15:0] ref_get(input int h);
    return ref_mem.exists(h) ? ref_mem[h] : 16'h0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int h = int'(a[AW:2]) * 2;
    return {ref_get(h + 1), ref_get(h)};
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] sel);
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        int h = int'(a[AW:2]) * 2 + b / 2;
        logic [15:0] v = ref_get(h);
        if (b % 2 == 0) v[7:0] = d[8*b +: 8];
        else            v[15:8] = d[8*b +: 8];
        ref_mem[h] = v;
      end
    end
  endtask

  task automatic preload(input int h, input logic [15:0] v);
    mem[h] = v;
    ref_mem[h] = v;
  endtask

  function automatic int exp_lat(input logic we, input logic [3:0] sel);
    int n = int'(|sel[1:0]) + int'(|sel[3:2]);
    if (!we) return 2 * W + 1;
    if (n == 0) return 1;
    if (n == 1) return W + 2;
    return 2 * W + 3;
  endfunction

  // Called at a negedge; returns at a negedge with the bus idle.
  task automatic xfer(input logic [31:0] a, input logic [31:0] d,
                      input logic we, input logic [3:0] sel,
                      output logic [31:0] rd, output int lat);
    bus.wb_adr_i = a;
    bus.wb_dat_i = d;
    bus.wb_we_i  = we;
    bus.wb_sel_i = sel;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    lat = -1;
    rd  = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.wb_ack_o) begin
        lat = k;
        rd  = bus.wb_dat_o;
        break;
      end
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    if (lat >= 0 && we) ref_wr(a, d, sel);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (pins() !== RST_VEC) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h", pins(), RST_VEC);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [31:0] rd;
    int lat;
    preload(16'h100, 16'h1234);
    preload(16'h101, 16'hABCD);
    rd_log.delete();
    xfer(32'h200, 32'h0, 1'b0, 4'hF, rd, lat);
    checks++;
    if (lat !== 2 * W + 1) begin
      failures++;
      $display("FAIL read_latency got=%0d want=%0d", lat, 2 * W + 1);
    end
    checks++;
    if (rd !== 32'hABCD1234) begin
      failures++;
      $display("FAIL read_data got=%h want=abcd1234", rd);
    end
    checks++;
    if (!(rd_log.size() == 4 && rd_log[0] == 18'h100 &&
          rd_log[1] == 18'h100 && rd_log[2] == 18'h101 &&
          rd_log[3] == 18'h101)) begin
      failures++;
      $display("FAIL read_phase_order got_n=%0d want 100,100,101,101",
               rd_log.size());
    end
  endtask

  task automatic test_write_full();
    logic [31:0] rd;
    int lat, w0, f0;
    w0 = we_low;
    f0 = we_fall;
    xfer(32'h204, 32'hCAFEF00D, 1'b1, 4'hF, rd, lat);
    checks++;
    if (lat !== 2 * W + 3) begin
      failures++;
      $display("FAIL wr_full_latency got=%0d want=%0d", lat, 2 * W + 3);
    end
    checks++;
    if (we_low - w0 !== 2 * W || we_fall - f0 !== 2) begin
      failures++;
      $display("FAIL wr_full_we_pulses got low=%0d edges=%0d want %0d/2",
               we_low - w0, we_fall - f0, 2 * W);
    end
    checks++;
    if ({mem[16'h103], mem[16'h102]} !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL wr_full_mem got=%h%h want=cafef00d",
               mem[16'h103], mem[16'h102]);
    end
    xfer(32'h204, 32'h0, 1'b0, 4'hF, rd, lat);
    checks++;
    if (rd !== ref_rd(32'h204)) begin
      failures++;
      $display("FAIL wr_full_readback got=%h want=%h", rd, ref_rd(32'h204));
    end
  endtask

  task automatic test_write_byte();
    logic [31:0] rd;
    int lat;
    preload(16'h104, 16'h5A5A);
    preload(16'h105, 16'h7777);
    xfer(32'h208, 32'h000000AA, 1'b1, 4'b0001, rd, lat);
    checks++;
    if (lat !== W + 2) begin
      failures++;
      $display("FAIL wr_byte_latency got=%0d want=%0d", lat, W + 2);
    end
    checks++;
    if (lb_seen !== 1'b0 || ub_seen !== 1'b1) begin
      failures++;
      $display("FAIL wr_byte_lanes got lb=%b ub=%b want lb=0 ub=1",
               lb_seen, ub_seen);
    end
    xfer(32'h208, 32'h0, 1'b0, 4'hF, rd, lat);
    checks++;
    if (rd !== 32'h77775AAA || rd !== ref_rd(32'h208)) begin
      failures++;
      $display("FAIL wr_byte_readback got=%h want=77775aaa", rd);
    end
  endtask

  task automatic test_sel_zero();
    int c0, lat, lat2, acks;
    logic [31:0] d0;
    c0 = ce_low;
    d0 = bus.wb_dat_o;
    lat = -1;
    lat2 = -1;
    acks = 0;
    bus.wb_adr_i = 32'h20C;
    bus.wb_dat_i = 32'h12345678;
    bus.wb_we_i  = 1'b1;
    bus.wb_sel_i = 4'b0000;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.wb_ack_o) begin lat = k; break; end
    end
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL sel0_latency got=%0d want=1", lat);
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.wb_ack_o) acks++;
    end
    checks++;
    if (acks !== 0) begin
      failures++;
      $display("FAIL sel0_stb_held_acks got=%0d want=0", acks);
    end
    bus.wb_stb_i = 1'b0;
    @(negedge clk);
    bus.wb_stb_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.wb_ack_o) begin lat2 = k; break; end
    end
    checks++;
    if (lat2 !== 1) begin
      failures++;
      $display("FAIL sel0_reaccept_latency got=%0d want=1", lat2);
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ce_low !== c0 || bus.wb_dat_o !== d0) begin
      failures++;
      $display("FAIL sel0_no_sram got ce_cycles=%0d dat=%h want 0/%h",
               ce_low - c0, bus.wb_dat_o, d0);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    int lat, acks;
    acks = 0;
    bus.wb_adr_i = 32'h200;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 4'hF;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    repeat (W + 2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sram_ce_n !== 1'b0 || sram_addr !== 18'h101) begin
      failures++;
      $display("FAIL abort_in_hi got ce_n=%b addr=%h want 0/101",
               sram_ce_n, sram_addr);
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    @(negedge clk);
    if (bus.wb_ack_o) acks++;
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
      failures++;
      $display("FAIL abort_strobes got=%b want=1110",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
    end
    repeat (5) begin
      @(negedge clk);
      if (bus.wb_ack_o) acks++;
    end
    checks++;
    if (acks !== 0) begin
      failures++;
      $display("FAIL abort_no_ack got=%0d want=0", acks);
    end
    xfer(32'h200, 32'h0, 1'b0, 4'hF, rd, lat);
    checks++;
    if (rd !== 32'hABCD1234 || lat !== 2 * W + 1) begin
      failures++;
      $display("FAIL abort_next_read got=%h lat=%0d want abcd1234/%0d",
               rd, lat, 2 * W + 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int lat, acks;
    acks = 0;
    bus.wb_adr_i = 32'h300;
    bus.wb_dat_i = 32'h11112222;
    bus.wb_we_i  = 1'b1;
    bus.wb_sel_i = 4'hF;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    repeat (W + 2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sram_we_n, sram_ce_n, sram_dq_oe} !== 3'b101) begin
      failures++;
      $display("FAIL rst_mid_hold got we_n,ce_n,oe=%b want 101",
               {sram_we_n, sram_ce_n, sram_dq_oe});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pins() !== RST_VEC) begin
      failures++;
      $display("FAIL rst_mid_async got=%h want=%h", pins(), RST_VEC);
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.wb_ack_o) acks++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.wb_ack_o) acks++;
    end
    checks++;
    if (acks !== 0) begin
      failures++;
      $display("FAIL rst_mid_no_ack got=%0d want=0", acks);
    end
    xfer(32'h0, 32'h0, 1'b0, 4'hF, rd, lat);
    checks++;
    if (rd !== ref_rd(32'h0) || lat !== 2 * W + 1) begin
      failures++;
      $display("FAIL rst_mid_read0 got=%h lat=%0d want %h/%0d",
               rd, lat, ref_rd(32'h0), 2 * W + 1);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd, exp;
    logic [3:0] sel;
    logic we;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a   = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      d   = $urandom;
      sel = 4'($urandom_range(0, 15));
      we  = 1'($urandom_range(0, 1));
      exp = ref_rd(a);
      xfer(a, d, we, sel, rd, lat);
      checks++;
      if (lat !== exp_lat(we, sel)) begin
        failures++;
        $display("FAIL rand_latency[%0d] we=%b sel=%b got=%0d want=%0d",
                 i, we, sel, lat, exp_lat(we, sel));
      end
      if (!we) begin
        checks++;
        if (rd !== exp) begin
          failures++;
          $display("FAIL rand_read[%0d] adr=%h got=%h want=%h",
                   i, a, rd, exp);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = '0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    test_reset();
    test_read();
    test_write_full();
    test_write_byte();
    test_sel_zero();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
